// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the hardwired control sequencer of the CPU.
//   state_t  : step sequence IDLE, T0..T7 (fetch T0-T2, execute T3-T7)
//   OPC_*    : opcode values of the memory-reference instructions
//   alu_op_t : ALU operation encodings
//   ctrl_t   : bundle of every control strobe the sequencer drives
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam int WCNT_W = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7
    } state_t;

    localparam logic [4:0] OPC_LD  = 5'b00000;
    localparam logic [4:0] OPC_LDI = 5'b00001;
    localparam logic [4:0] OPC_ST  = 5'b00010;

    typedef enum logic [2:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
    } alu_op_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic mdr_in;
        logic read;
        logic mdr_out;
        logic ir_in;
        logic pc_in;
        logic inc_pc;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic c_out;
        logic y_in;
        logic z_high_in;
        logic z_low_in;
        logic z_low_out;
        logic alu_add;
        logic ram_write;
        logic done;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/ld_st_control_unit.sv
// ---------------------------------------------------------------------------
// ld_st_control_unit
// Hardwired control sequencer for ld, ldi and st. Steps through the shared
// fetch (T0-T2) and the per-opcode execute steps (T3-T7), driving DataPath
// enables and bus-source selects. RAM access steps stretch by MEM_WAIT.
//
// Ports:
//   clock, clear (async, active high), run (level: keep executing)
//   opcode  : IR[31:27] from DataPath, captured on the T2->T3 edge
//   PCout..IncPC, Gra..Cout, Yin..ZLowout, alu_add, RAM_write : strobes
//   done    : one-cycle pulse in the final step of an instruction
//   illegal : one-cycle pulse in T3 for an unsupported opcode
//
// All outputs come straight from flops: the decode below works on the
// state being entered, so each strobe is valid for the whole cycle in
// which its state is occupied.
// ---------------------------------------------------------------------------
module ld_st_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int OPC_W    = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    output logic             PCout,
    output logic             MARin,
    output logic             MDRin,
    output logic             Read,
    output logic             MDRout,
    output logic             IRin,
    output logic             PCin,
    output logic             IncPC,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             Cout,
    output logic             Yin,
    output logic             ZHighIn,
    output logic             ZLowIn,
    output logic             ZLowout,
    output logic             alu_add,
    output logic             RAM_write,
    output logic             done,
    output logic             illegal
);

    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(MEM_WAIT);
    localparam logic [OPC_W-1:0]  LD_CODE   = OPC_W'(OPC_LD);
    localparam logic [OPC_W-1:0]  LDI_CODE  = OPC_W'(OPC_LDI);
    localparam logic [OPC_W-1:0]  ST_CODE   = OPC_W'(OPC_ST);

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [OPC_W-1:0]  op_q, op_d;
    ctrl_t             ctrl_q, ctrl_d;
    alu_op_t           alu_op_d;

    function automatic logic op_legal(input logic [OPC_W-1:0] o);
        return (o == LD_CODE) || (o == LDI_CODE) || (o == ST_CODE);
    endfunction

    // State, wait counter, latched opcode and registered strobes. clear
    // drops every strobe at once, so an interrupted st cannot keep
    // RAM_write asserted.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            op_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next-state logic. RAM steps load the wait counter on entry and hold
    // until it has counted down to zero. The final step of an instruction
    // goes straight to T0 when run is high so there is no idle bubble.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                state_d = S_T1;
                wcnt_d  = WAIT_INIT;
            end
            S_T1: begin
                if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
                else              state_d = S_T2;
            end
            S_T2: begin
                state_d = S_T3;
                op_d    = opcode;
            end
            S_T3: begin
                state_d = op_legal(op_q) ? S_T4 : S_IDLE;
            end
            S_T4: begin
                state_d = S_T5;
            end
            S_T5: begin
                if (op_q == LDI_CODE) begin
                    state_d = run ? S_T0 : S_IDLE;
                end else begin
                    state_d = S_T6;
                    wcnt_d  = (op_q == ST_CODE) ? '0 : WAIT_INIT;
                end
            end
            S_T6: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    state_d = S_T7;
                    wcnt_d  = (op_q == ST_CODE) ? WAIT_INIT : '0;
                end
            end
            S_T7: begin
                if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
                else              state_d = run ? S_T0 : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode for the state being entered. PCin is limited to the
    // first T1 cycle so a stretched fetch does not reload PC repeatedly;
    // st signals done only in the last RAM_write cycle.
    always_comb begin
        ctrl_d   = '0;
        alu_op_d = ALU_NOP;
        case (state_d)
            S_T0: begin
                ctrl_d.pc_out    = 1'b1;
                ctrl_d.mar_in    = 1'b1;
                ctrl_d.inc_pc    = 1'b1;
                ctrl_d.z_high_in = 1'b1;
                ctrl_d.z_low_in  = 1'b1;
            end
            S_T1: begin
                ctrl_d.z_low_out = 1'b1;
                ctrl_d.pc_in     = (state_q != S_T1);
                ctrl_d.read      = 1'b1;
                ctrl_d.mdr_in    = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            S_T3: begin
                if (op_legal(op_d)) begin
                    ctrl_d.grb    = 1'b1;
                    ctrl_d.ba_out = 1'b1;
                    ctrl_d.y_in   = 1'b1;
                end else begin
                    ctrl_d.illegal = 1'b1;
                end
            end
            S_T4: begin
                ctrl_d.c_out     = 1'b1;
                alu_op_d         = ALU_ADD;
                ctrl_d.z_high_in = 1'b1;
                ctrl_d.z_low_in  = 1'b1;
            end
            S_T5: begin
                ctrl_d.z_low_out = 1'b1;
                if (op_d == LDI_CODE) begin
                    ctrl_d.gra  = 1'b1;
                    ctrl_d.r_in = 1'b1;
                    ctrl_d.done = 1'b1;
                end else begin
                    ctrl_d.mar_in = 1'b1;
                end
            end
            S_T6: begin
                ctrl_d.mdr_in = 1'b1;
                if (op_d == ST_CODE) begin
                    ctrl_d.gra   = 1'b1;
                    ctrl_d.r_out = 1'b1;
                end else begin
                    ctrl_d.read = 1'b1;
                end
            end
            S_T7: begin
                if (op_d == ST_CODE) begin
                    ctrl_d.ram_write = 1'b1;
                    ctrl_d.done      = (wcnt_d == '0);
                end else begin
                    ctrl_d.mdr_out = 1'b1;
                    ctrl_d.gra     = 1'b1;
                    ctrl_d.r_in    = 1'b1;
                    ctrl_d.done    = 1'b1;
                end
            end
            default: begin
                ctrl_d = '0;
            end
        endcase
        ctrl_d.alu_add = (alu_op_d == ALU_ADD);
    end

    assign PCout     = ctrl_q.pc_out;
    assign MARin     = ctrl_q.mar_in;
    assign MDRin     = ctrl_q.mdr_in;
    assign Read      = ctrl_q.read;
    assign MDRout    = ctrl_q.mdr_out;
    assign IRin      = ctrl_q.ir_in;
    assign PCin      = ctrl_q.pc_in;
    assign IncPC     = ctrl_q.inc_pc;
    assign Gra       = ctrl_q.gra;
    assign Grb       = ctrl_q.grb;
    assign Grc       = ctrl_q.grc;
    assign Rin       = ctrl_q.r_in;
    assign Rout      = ctrl_q.r_out;
    assign BAout     = ctrl_q.ba_out;
    assign Cout      = ctrl_q.c_out;
    assign Yin       = ctrl_q.y_in;
    assign ZHighIn   = ctrl_q.z_high_in;
    assign ZLowIn    = ctrl_q.z_low_in;
    assign ZLowout   = ctrl_q.z_low_out;
    assign alu_add   = ctrl_q.alu_add;
    assign RAM_write = ctrl_q.ram_write;
    assign done      = ctrl_q.done;
    assign illegal   = ctrl_q.illegal;

endmodule

// File: doc/ld_st_control_unit.md
Name: ld_st_control_unit

Overview:
- Hardwired control sequencer for the memory-reference instructions ld, ldi and st.
- Produces, cycle by cycle, the DataPath control strobes for the shared fetch (T0-T2) and per-opcode execute (T3-T7) step sequence.
- Sits beside DataPath. Takes the IR opcode back from DataPath and drives its enables and bus-select lines.
- Replaces hand-driven stimulus with an FSM, so DataPath runs programs autonomously.

Parameters:
- MEM_WAIT, 0: extra stall cycles added to every RAM access step (T1 fetch read, ld T6 read, st T7 write); range 0-15.
- OPC_W, 5: opcode width.

Ports:
- clock, in, 1: single system clock; all state changes on the rising edge.
- clear, in, 1: asynchronous active-high reset.
- run, in, 1: level; while high the unit fetches and executes instructions back to back.
- opcode, in, OPC_W: IR[31:27] from DataPath; sampled only on entry to T3.
- PCout, MARin, MDRin, Read, MDRout, IRin, PCin, IncPC, out, 1 each: fetch/memory strobes.
- Gra, Grb, Grc, Rin, Rout, BAout, Cout, out, 1 each: register-select and bus-source strobes.
- Yin, ZHighIn, ZLowIn, ZLowout, out, 1 each: ALU operand/result strobes.
- alu_add, out, 1: ALU operation select = ADD; high in T4.
- RAM_write, out, 1: memory write enable.
- done, out, 1: one-cycle pulse in the final step of each instruction.
- illegal, out, 1: one-cycle pulse when the opcode is not ld/ldi/st.

Behaviour:
- Reset and outputs:
  - clear=1 forces state IDLE and every output to 0 immediately, regardless of phase.
  - A reset during T6/T7 of st must never leave RAM_write high.
  - All outputs are registered Moore outputs. They are valid for the whole cycle in which a state is occupied. No output is combinational from inputs.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, T7. A 4-bit wait counter (wcnt) runs alongside.
- IDLE: all outputs 0. If run=1, go to T0.
- T0: PCout, MARin, IncPC, Zin (ZHighIn+ZLowIn). Next is T1.
- T1: ZLowout, PCin, Read, MDRin.
  - Stays in T1 for MEM_WAIT extra cycles; wcnt loads MEM_WAIT on entry and decrements.
  - PCin is asserted only in the first T1 cycle. Read and MDRin hold throughout.
  - Next is T2.
- T2: MDRout, IRin. Next is T3. The opcode is latched into op_q on the T2->T3 edge.
- ld (00000):
  - T3: Grb, BAout, Yin.
  - T4: Cout, alu_add, ZHighIn, ZLowIn.
  - T5: ZLowout, MARin.
  - T6: Read, MDRin; held 1+MEM_WAIT cycles.
  - T7: MDRout, Gra, Rin, done.
- ldi (00001):
  - T3 and T4 as for ld.
  - T5: ZLowout, Gra, Rin, done. Skips T6 and T7.
- st (00010):
  - T3 to T5 as for ld.
  - T6: Gra, Rout, MDRin, with Read=0 (MDR takes the bus).
  - T7: RAM_write; held 1+MEM_WAIT cycles. done is asserted in the last T7 cycle only.
- Any other opcode: in T3, assert illegal for one cycle, with no datapath strobes. Then go to IDLE.
- After the last step: if run=1, go to T0 (next fetch immediately, no bubble); else go to IDLE.
- Deasserting run mid-instruction has no effect; the instruction completes.
- Address arithmetic belongs to the DataPath (Rb/BAout + C sign-extended). The unit only sequences it. BAout with Rb=r0 yields 0 in DataPath; the unit needs no special case.
- Invariant: at most one bus driver is high in any cycle (PCout, MDRout, ZLowout, Rout, Cout, BAout). BAout and Cout are in different steps.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state enum (IDLE, T0-T7);
  - opcode constants OPC_LD=5'b00000, OPC_LDI=5'b00001, OPC_ST=5'b00010;
  - ALU op encodings.
- No sub-module is required. The wait counter is inline.
- One state register plus one registered output-decode block.

Test Plan:
- ld r1,7 (IR 0x00800007, mem[7]=15, MEM_WAIT=0), run held high:
  - T0..T7 each last 1 cycle, in the exact strobe sets above;
  - done is high in cycle 8 after start;
  - the DataPath bench sees r1=15.
- ld r1,2(r2) (0x00900002, r2=2, mem[4]=15):
  - MARin in T5 with the bus carrying 4;
  - r1=15 after T7;
  - done pulses once.
- ldi r1,2(r2) (0x08900002):
  - the sequence ends at T5 with Gra+Rin+done;
  - r1=4;
  - the next fetch T0 occurs in the following cycle when run=1.
- st 0x57,r1 (0x10800057, r1=0x1F), MEM_WAIT=2:
  - T7 RAM_write is high for exactly 3 cycles;
  - mem[0x57]=0x1F;
  - T1 lasts 3 cycles, with PCin only in the first.
- Opcode 5'b11111:
  - illegal pulses once in T3;
  - no Yin, Zin or RAM_write;
  - the unit returns to IDLE.
- clear asserted asynchronously mid-T7 of st:
  - all outputs go to 0 before the next edge;
  - state is IDLE;
  - the memory location is unchanged if clear arrives before the write edge.
